// File: rtl/cmp_pkg.sv
// Shared definitions for the serial inequality comparator: FSM state
// encoding and the default operand word width.
package cmp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } cmp_state_t;

    localparam int CMP_WIDTH_DEFAULT = 5;

endpackage

// File: rtl/sticky_xor_cell.sv
// One-bit XOR followed by a sticky-OR register. o_next is the value the
// sticky flag takes on an enabled edge, so the parent can use it as the
// word result on the edge that accepts the final bit.
module sticky_xor_cell
    import cmp_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    input  logic i_a,
    input  logic i_b,
    output logic o_next
);

    logic r_sticky;
    logic w_diff;

    assign w_diff = i_a ^ i_b;
    // A clear starts a new word, so earlier differences are dropped.
    assign o_next = i_clear ? w_diff : (r_sticky | w_diff);

    // Update the sticky difference flag whenever a bit is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= 1'b0;
        end else if (i_en) begin
            r_sticky <= o_next;
        end
    end

endmodule

// File: rtl/serial_inequality_comparator.sv
// Bit-serial inequality comparator. It takes two LSB-first operand streams
// and reports one registered neq result per WIDTH-bit word.
// Optional feature macro: SERIAL_CMP_CAPTURE_EN adds the a_word/b_word
// outputs, which hold the deserialised operands of the last word.
module serial_inequality_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         bit_valid,
    input  logic                         a_bit,
    input  logic                         b_bit,
    output logic                         busy,
    output logic [$clog2(WIDTH+1)-1:0]   bit_count,
    output logic                         neq_valid,
    output logic                         neq,
    output logic                         aborted
`ifdef SERIAL_CMP_CAPTURE_EN
    ,
    output logic [WIDTH-1:0]             a_word,
    output logic [WIDTH-1:0]             b_word
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    cmp_state_t      r_state;
    cmp_state_t      w_state_n;
    logic [CW-1:0]   r_bit_count;
    logic [CW-1:0]   w_bit_count_n;
    logic            r_neq_valid;
    logic            w_neq_valid_n;
    logic            r_neq;
    logic            w_neq_n;
    logic            r_aborted;
    logic            w_aborted_n;
    logic            w_accept;
    logic            w_sticky_next;

    // A bit only enters the sticky path when it starts or continues a word.
    assign w_accept = bit_valid & (start | (r_state == RECV));

    sticky_xor_cell u_sticky (
        .clk     (clk),
        .rst     (rst),
        .i_clear (start),
        .i_en    (w_accept),
        .i_a     (a_bit),
        .i_b     (b_bit),
        .o_next  (w_sticky_next)
    );

    // State, counter and result registers; reset discards any word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bit_count <= '0;
            r_neq_valid <= 1'b0;
            r_neq       <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_bit_count <= w_bit_count_n;
            r_neq_valid <= w_neq_valid_n;
            r_neq       <= w_neq_n;
            r_aborted   <= w_aborted_n;
        end
    end

    // Next-state logic: start/accept, abort on early start, completion on the last bit.
    always_comb begin
        w_state_n     = r_state;
        w_bit_count_n = r_bit_count;
        w_neq_valid_n = 1'b0;
        w_neq_n       = r_neq;
        w_aborted_n   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bit_valid && start) begin
                    if (WIDTH == 1) begin
                        // A single-bit word is complete on its first bit.
                        w_neq_n       = w_sticky_next;
                        w_neq_valid_n = 1'b1;
                        w_bit_count_n = '0;
                    end else begin
                        w_bit_count_n = CW'(1);
                        w_state_n     = RECV;
                    end
                end
            end
            RECV: begin
                if (bit_valid) begin
                    if (start) begin
                        // Restart: this bit becomes bit 0 of a fresh word.
                        w_aborted_n   = 1'b1;
                        w_bit_count_n = CW'(1);
                    end else if (r_bit_count == LAST_IDX) begin
                        w_neq_n       = w_sticky_next;
                        w_neq_valid_n = 1'b1;
                        w_bit_count_n = '0;
                        w_state_n     = IDLE;
                    end else begin
                        w_bit_count_n = r_bit_count + CW'(1);
                    end
                end
            end
            default: begin
                w_state_n     = IDLE;
                w_bit_count_n = '0;
            end
        endcase
    end

    assign busy      = (r_state == RECV);
    assign bit_count = r_bit_count;
    assign neq_valid = r_neq_valid;
    assign neq       = r_neq;
    assign aborted   = r_aborted;

`ifdef SERIAL_CMP_CAPTURE_EN
    logic [WIDTH-1:0] r_a_shift;
    logic [WIDTH-1:0] r_b_shift;
    logic [WIDTH-1:0] r_a_word;
    logic [WIDTH-1:0] r_b_word;
    logic [WIDTH-1:0] w_a_shift_n;
    logic [WIDTH-1:0] w_b_shift_n;

    // New bits enter at the MSB so that after WIDTH bits bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign w_a_shift_n = a_bit;
            assign w_b_shift_n = b_bit;
        end else begin : g_shift_wn
            assign w_a_shift_n = {a_bit, r_a_shift[WIDTH-1:1]};
            assign w_b_shift_n = {b_bit, r_b_shift[WIDTH-1:1]};
        end
    endgenerate

    // Shift accepted bits in; publish the words together with neq.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_shift <= '0;
            r_b_shift <= '0;
            r_a_word  <= '0;
            r_b_word  <= '0;
        end else begin
            if (w_accept) begin
                r_a_shift <= w_a_shift_n;
                r_b_shift <= w_b_shift_n;
            end
            if (w_neq_valid_n) begin
                r_a_word <= w_a_shift_n;
                r_b_word <= w_b_shift_n;
            end
        end
    end

    assign a_word = r_a_word;
    assign b_word = r_b_word;
`endif

endmodule

// File: tb/tb_serial_inequality_comparator.sv
// Directed bench for serial_inequality_comparator at WIDTH=5. Inputs change
// on the falling edge; outputs are sampled 1 time unit after the rising edge.
// Optional feature macro: SERIAL_CMP_CAPTURE_EN enables the a_word/b_word checks.
module tb_serial_inequality_comparator;

    localparam int W = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       bit_valid;
    logic       a_bit;
    logic       b_bit;
    logic       busy;
    logic [2:0] bit_count;
    logic       neq_valid;
    logic       neq;
    logic       aborted;
`ifdef SERIAL_CMP_CAPTURE_EN
    logic [W-1:0] a_word;
    logic [W-1:0] b_word;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    serial_inequality_comparator #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_valid (bit_valid),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .busy      (busy),
        .bit_count (bit_count),
        .neq_valid (neq_valid),
        .neq       (neq),
        .aborted   (aborted)
`ifdef SERIAL_CMP_CAPTURE_EN
        ,
        .a_word    (a_word),
        .b_word    (b_word)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Drive one cycle of inputs and return just after the accepting edge.
    task automatic step(input logic v, input logic s, input logic a, input logic b);
        @(negedge clk);
        bit_valid = v;
        start     = s;
        a_bit     = a;
        b_bit     = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (bit_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bit_count); end
        total++; if (neq_valid !== 1'b0) begin bad++; $display("FAIL reset_neq_valid got=%b want=0", neq_valid); end
        total++; if (neq !== 1'b0) begin bad++; $display("FAIL reset_neq got=%b want=0", neq); end
        total++; if (aborted !== 1'b0) begin bad++; $display("FAIL reset_aborted got=%b want=0", aborted); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_idle_ignore();
        step(1'b1, 1'b0, 1'b1, 1'b0);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_ignore_busy got=%b want=0", busy); end
        total++; if (bit_count !== 3'd0) begin bad++; $display("FAIL idle_ignore_count got=%0d want=0", bit_count); end
    endtask

    task automatic test_equal();
        logic [W-1:0] a;
        a = 5'b00001;
        for (int i = 0; i < W; i++) begin
            step(1'b1, i == 0, a[i], a[i]);
            if (i < W - 1) begin
                total++; if (bit_count !== 3'(i + 1)) begin bad++; $display("FAIL equal_count got=%0d want=%0d", bit_count, i + 1); end
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL equal_busy got=%b want=1", busy); end
                total++; if (neq_valid !== 1'b0) begin bad++; $display("FAIL equal_early_valid got=%b want=0", neq_valid); end
            end
        end
        total++; if (neq_valid !== 1'b1) begin bad++; $display("FAIL equal_valid got=%b want=1", neq_valid); end
        total++; if (neq !== 1'b0) begin bad++; $display("FAIL equal_neq got=%b want=0", neq); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL equal_busy_end got=%b want=0", busy); end
        total++; if (bit_count !== 3'd0) begin bad++; $display("FAIL equal_count_end got=%0d want=0", bit_count); end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (neq_valid !== 1'b0) begin bad++; $display("FAIL equal_pulse_width got=%b want=0", neq_valid); end
    endtask

    task automatic test_differ();
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = 5'b00101;
        b = 5'b00011;
        for (int i = 0; i < W; i++) begin
            step(1'b1, i == 0, a[i], b[i]);
        end
        total++; if (neq_valid !== 1'b1) begin bad++; $display("FAIL differ_valid got=%b want=1", neq_valid); end
        total++; if (neq !== 1'b1) begin bad++; $display("FAIL differ_neq got=%b want=1", neq); end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (neq !== 1'b1) begin bad++; $display("FAIL differ_neq_held got=%b want=1", neq); end
    endtask

    task automatic test_stall();
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            total++; if (bit_count !== 3'd2) begin bad++; $display("FAIL stall_count got=%0d want=2", bit_count); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL stall_busy got=%b want=1", busy); end
        end
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        total++; if (neq_valid !== 1'b0) begin bad++; $display("FAIL stall_early_valid got=%b want=0", neq_valid); end
        step(1'b1, 1'b0, 1'b1, 1'b1);
        total++; if (neq_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b want=1", neq_valid); end
        total++; if (neq !== 1'b0) begin bad++; $display("FAIL stall_neq got=%b want=0", neq); end
    endtask

    task automatic test_abort();
        logic [W-1:0] a;
        logic [W-1:0] b;
        // Three bits of a word that would differ, then restart.
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        a = 5'b10101;
        b = 5'b01010;
        for (int i = 0; i < W; i++) begin
            step(1'b1, i == 0, a[i], b[i]);
            if (i == 0) begin
                total++; if (aborted !== 1'b1) begin bad++; $display("FAIL abort_pulse got=%b want=1", aborted); end
                total++; if (neq_valid !== 1'b0) begin bad++; $display("FAIL abort_no_valid got=%b want=0", neq_valid); end
                total++; if (bit_count !== 3'd1) begin bad++; $display("FAIL abort_count got=%0d want=1", bit_count); end
            end else if (i == 1) begin
                total++; if (aborted !== 1'b0) begin bad++; $display("FAIL abort_pulse_width got=%b want=0", aborted); end
            end
        end
        total++; if (neq_valid !== 1'b1) begin bad++; $display("FAIL abort_valid got=%b want=1", neq_valid); end
        total++; if (neq !== 1'b1) begin bad++; $display("FAIL abort_neq got=%b want=1", neq); end
        total++; if (aborted !== 1'b0) begin bad++; $display("FAIL abort_with_valid got=%b want=0", aborted); end
`ifdef SERIAL_CMP_CAPTURE_EN
        total++; if (a_word !== 5'b10101) begin bad++; $display("FAIL capture_a got=%b want=10101", a_word); end
        total++; if (b_word !== 5'b01010) begin bad++; $display("FAIL capture_b got=%b want=01010", b_word); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a;
        logic [W-1:0] b;
        int first_cyc;
        a = 5'b00000;
        b = 5'b00000;
        for (int i = 0; i < W; i++) step(1'b1, i == 0, a[i], b[i]);
        first_cyc = cyc;
        total++; if (neq_valid !== 1'b1 || neq !== 1'b0) begin bad++; $display("FAIL b2b_first got=%b/%b want=1/0", neq_valid, neq); end
        a = 5'b11111;
        b = 5'b11110;
        for (int i = 0; i < W; i++) begin
            step(1'b1, i == 0, a[i], b[i]);
            if (i == 0) begin
                total++; if (busy !== 1'b1 || bit_count !== 3'd1) begin bad++; $display("FAIL b2b_restart got=%b/%0d want=1/1", busy, bit_count); end
            end
        end
        total++; if (neq_valid !== 1'b1 || neq !== 1'b1) begin bad++; $display("FAIL b2b_second got=%b/%b want=1/1", neq_valid, neq); end
        total++; if (cyc - first_cyc !== 5) begin bad++; $display("FAIL b2b_spacing got=%0d want=5", cyc - first_cyc); end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        total++; if (bit_count !== 3'd0) begin bad++; $display("FAIL rstmid_count got=%0d want=0", bit_count); end
        total++; if (neq !== 1'b0) begin bad++; $display("FAIL rstmid_neq got=%b want=0", neq); end
        @(negedge clk);
        rst = 1'b0;
        bit_valid = 1'b1; start = 1'b0; a_bit = 1'b1; b_bit = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            total++; if (neq_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_no_result got=%b/%b want=0/0", neq_valid, busy); end
        end
        bit_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_equal();
        test_differ();
        test_stall();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
